mips_muldiv: RTL and testbench
==============================

Name: mips_muldiv

Overview:
Iterative multiply/divide unit directly downstream of the MIPS register file. Consumes the two register read-port values (Rs on R_Data_C, Rt on R_Data_B) and produces the HI/LO pair for MULT/MULTU/DIV/DIVU. Also serves MTHI/MTLO writes and MFHI/MFLO reads. Runs one shift-add or restoring-subtract step per cycle, with a start/busy/done handshake toward the controller.

Parameters:
WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
Clk  in  1  system clock, rising edge.
Reset  in  1  synchronous, active-high; clears all state.
Start  in  1  request a new operation; sampled only in IDLE.
Op  in  2  00 MULTU, 01 DIVU, 10 MULT, 11 DIV.
A  in  WIDTH  Rs operand (multiplicand or dividend).
B  in  WIDTH  Rt operand (multiplier or divisor).
Write_HI  in  1  MTHI strobe.
Write_LO  in  1  MTLO strobe.
W_Data  in  WIDTH  data for MTHI/MTLO.
Busy  out  1  high while an operation is in flight.
Done  out  1  one-cycle pulse when HI/LO are updated by an operation.
Div_Zero  out  1  high together with Done when a divide had B==0.
HI  out  WIDTH  HI register (remainder or product high word).
LO  out  WIDTH  LO register (quotient or product low word).

Behaviour:
- Clocking and reset: single clock Clk; Reset is synchronous and active-high.
- Reset values: state IDLE, Busy=0, Done=0, Div_Zero=0, HI=0, LO=0, iteration counter 0.
- Reset asserted mid-operation aborts the operation. No Done is issued and HI/LO become 0 at that edge.
- FSM states: IDLE, CALC, FIN.
  - IDLE->CALC on Start=1: latch Op, A and B (absolute values for signed ops), clear the partial accumulator, set counter=0.
  - CALC: one iteration per cycle. When counter==WIDTH-1, go to FIN at that edge.
  - FIN: write HI/LO with sign fix-up applied; Done=1 and Div_Zero valid for exactly this one cycle; then return to IDLE.
- Busy=1 in CALC and FIN, 0 in IDLE.
- Latency: Start sampled at edge t. Done is high in the cycle after edge t+WIDTH+1, which is 33 cycles for WIDTH=32. HI/LO hold their old values until that edge.
- Start while Busy=1 is ignored. It is not queued.
- Multiply: unsigned shift-add. The 2*WIDTH product goes to {HI,LO}.
- Divide: restoring division. Quotient goes to LO, remainder to HI.
- Divide by zero (B==0, any divide op): full latency still elapses. Result HI=A (raw input), LO=all ones, Div_Zero=1.
- Signed results: quotient sign is sign(A)^sign(B); remainder sign is sign(A); product sign is sign(A)^sign(B).
- Signed overflow case 0x8000_0000 / 0xFFFF_FFFF: LO=0x8000_0000, HI=0.
- MTHI/MTLO:
  - In IDLE, Write_HI/Write_LO load W_Data at the next edge.
  - Both may be asserted in the same cycle.
  - If Start and a write arrive in the same cycle, the write takes effect and the operation starts. Its later FIN overwrites HI/LO.
  - Writes while Busy=1 are ignored.
- HI/LO outputs are direct register outputs. MFHI/MFLO read combinationally from them.

Optional Feature:
MULDIV_SIGNED_EN.
- Defined: Op 10/11 perform signed MULT/DIV with the sign rules above.
- Undefined: no abs/negate logic is built, and Op[1] is ignored, so MULT behaves as MULTU and DIV behaves as DIVU.

Decomposition:
- Shared package mips_muldiv_pkg holds:
  - Op encodings: OP_MULTU, OP_DIVU, OP_MULT, OP_DIV.
  - FSM state encodings: S_IDLE, S_CALC, S_FIN.
  - The default WIDTH constant.
- One natural sub-module, mips_muldiv_signfix: combinational abs-in and negate-out helpers, instantiated only under MULDIV_SIGNED_EN.
- The FSM and datapath stay in mips_muldiv.

Test Plan:
1. MULTU A=0xFFFF_FFFF, B=0xFFFF_FFFF, Start pulse -> Busy=1 next cycle; Done 33 cycles after Start; HI=0xFFFF_FFFE, LO=0x0000_0001.
2. MULT A=0xFFFF_FFFD (-3), B=7:
   - With MULDIV_SIGNED_EN: HI=0xFFFF_FFFF, LO=0xFFFF_FFEB.
   - Without: HI=0x0000_0006, LO=0xFFFF_FFEB.
3. DIVU A=100, B=7 -> LO=0x0000_000E, HI=0x0000_0002, Div_Zero=0. DIV A=0xFFFF_FFF9 (-7), B=2 (signed build) -> LO=0xFFFF_FFFD, HI=0xFFFF_FFFF.
4. DIVU A=5, B=0 -> Done at cycle 33, HI=0x0000_0005, LO=0xFFFF_FFFF, Div_Zero=1 for exactly one cycle.
5. Handshake and writes:
   - Start MULTU 2*3.
   - Assert Start (DIVU 9/3) and Write_HI=0xDEAD_BEEF at cycle 5: both ignored.
   - Done yields HI=0, LO=6.
   - Then in IDLE, Write_LO=0x1234_5678 -> LO=0x1234_5678 next cycle.
6. Start MULTU 0xFFFF_FFFF*2, assert Reset at cycle 10 -> next cycle Busy=0, HI=LO=0; no Done pulse follows.

Source files
------------

// File: rtl/mips_muldiv_pkg.sv
// Shared definitions for the MIPS multiply/divide unit.
//   - Op encodings seen on the Op bus (bit 0 selects divide, bit 1 selects signed).
//   - FSM state encodings.
//   - Default operand / HI / LO width.
package mips_muldiv_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_DIVU  = 2'b01,
        OP_MULT  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIN  = 2'b10
    } state_e;

endpackage

// File: rtl/mips_muldiv_if.sv
// Controller <-> multiply/divide unit bus.
//   master (controller): drives Start, Op, A, B, Write_HI, Write_LO, W_Data;
//                        observes Busy, Done, Div_Zero, HI, LO.
//   slave  (unit)      : the mirror image.
// Clock and reset are not part of this bundle.
interface mips_muldiv_if #(parameter int WIDTH = 32);

    logic             Start;
    logic [1:0]       Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Write_HI;
    logic             Write_LO;
    logic [WIDTH-1:0] W_Data;
    logic             Busy;
    logic             Done;
    logic             Div_Zero;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output Start, Op, A, B, Write_HI, Write_LO, W_Data,
        input  Busy, Done, Div_Zero, HI, LO
    );

    modport slave (
        input  Start, Op, A, B, Write_HI, Write_LO, W_Data,
        output Busy, Done, Div_Zero, HI, LO
    );

endinterface

// File: rtl/mips_muldiv_signfix.sv
// Sign handling around the unsigned multiply/divide core (signed build only).
//   Inputs : is_signed, a, b        - live operands and signedness at Start
//            is_div, neg_a, neg_b   - latched op kind and operand sign flags
//            raw_hi, raw_lo         - unsigned core result
//   Outputs: a_abs, b_abs           - magnitudes fed to the core
//            a_neg, b_neg           - operand sign flags to latch
//            fix_hi, fix_lo         - result with signs restored
module mips_muldiv_signfix #(
    parameter int WIDTH = 32
) (
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] a_abs,
    output logic [WIDTH-1:0] b_abs,
    output logic             a_neg,
    output logic             b_neg,
    input  logic             is_div,
    input  logic             neg_a,
    input  logic             neg_b,
    input  logic [WIDTH-1:0] raw_hi,
    input  logic [WIDTH-1:0] raw_lo,
    output logic [WIDTH-1:0] fix_hi,
    output logic [WIDTH-1:0] fix_lo
);

    logic [2*WIDTH-1:0] prod_neg_s;

    // Magnitudes of the incoming operands; 0x8000_0000 maps to itself, which
    // is the correct unsigned magnitude.
    always_comb begin
        a_neg = is_signed & a[WIDTH-1];
        b_neg = is_signed & b[WIDTH-1];
        a_abs = a_neg ? (-a) : a;
        b_abs = b_neg ? (-b) : b;
    end

    // Restore result signs: product and quotient take sign(A)^sign(B),
    // remainder takes sign(A).
    always_comb begin
        prod_neg_s = -{raw_hi, raw_lo};
        if (is_div) begin
            fix_lo = (neg_a ^ neg_b) ? (-raw_lo) : raw_lo;
            fix_hi = neg_a ? (-raw_hi) : raw_hi;
        end else if (neg_a ^ neg_b) begin
            {fix_hi, fix_lo} = prod_neg_s;
        end else begin
            {fix_hi, fix_lo} = {raw_hi, raw_lo};
        end
    end

endmodule

// File: rtl/mips_muldiv.sv
// Iterative MIPS HI/LO multiply/divide unit: one shift-add (multiply) or
// restoring-subtract (divide) step per clock, WIDTH steps per operation.
//   Clk, Reset : clock and synchronous active-high reset
//   bus        : mips_muldiv_if.slave (Start/Op/A/B, MTHI/MTLO writes,
//                Busy/Done/Div_Zero handshake, HI/LO registers)
// Build option: define MULDIV_SIGNED_EN for signed MULT/DIV; without it
// Op[1] is ignored and MULT/DIV behave as MULTU/DIVU.
module mips_muldiv
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic          Clk,
    input  logic          Reset,
    mips_muldiv_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_r, state_next;
    logic [CNT_W-1:0]   cnt_r;
    logic               is_div_r;
    logic               b_zero_r;
    logic [WIDTH-1:0]   a_raw_r;
    logic [WIDTH-1:0]   d_r;        // multiplicand or divisor
    logic [WIDTH-1:0]   acc_hi_r;   // partial product high / remainder
    logic [WIDTH-1:0]   acc_lo_r;   // multiplier / dividend-then-quotient
    logic [WIDTH-1:0]   hi_r, lo_r;
    logic               busy_r, done_r, div_zero_r;

    logic [WIDTH-1:0]   a_abs_s, b_abs_s, fix_hi_s, fix_lo_s;
    logic [WIDTH-1:0]   step_hi_s, step_lo_s, res_hi_s, res_lo_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH+1:0]   div_diff_s;

`ifdef MULDIV_SIGNED_EN
    logic a_neg_s, b_neg_s, neg_a_r, neg_b_r;

    mips_muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
        .is_signed (bus.Op[1]),
        .a         (bus.A),
        .b         (bus.B),
        .a_abs     (a_abs_s),
        .b_abs     (b_abs_s),
        .a_neg     (a_neg_s),
        .b_neg     (b_neg_s),
        .is_div    (is_div_r),
        .neg_a     (neg_a_r),
        .neg_b     (neg_b_r),
        .raw_hi    (acc_hi_r),
        .raw_lo    (acc_lo_r),
        .fix_hi    (fix_hi_s),
        .fix_lo    (fix_lo_s)
    );

    // Operand sign flags captured at Start.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            neg_a_r <= 1'b0;
            neg_b_r <= 1'b0;
        end else if (state_r == S_IDLE && bus.Start) begin
            neg_a_r <= a_neg_s;
            neg_b_r <= b_neg_s;
        end
    end
`else
    assign a_abs_s  = bus.A;
    assign b_abs_s  = bus.B;
    assign fix_hi_s = acc_hi_r;
    assign fix_lo_s = acc_lo_r;
`endif

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_r;
        case (state_r)
            S_IDLE:  if (bus.Start) state_next = S_CALC; else state_next = S_IDLE;
            S_CALC:  if (cnt_r == CNT_LAST) state_next = S_FIN; else state_next = S_CALC;
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // One multiply or divide iteration; divide shifts the next dividend bit
    // into the remainder and keeps the difference only when it did not borrow.
    always_comb begin
        mul_sum_s   = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, d_r} : {(WIDTH+1){1'b0}});
        div_shift_s = {acc_hi_r, acc_lo_r[WIDTH-1]};
        div_diff_s  = {1'b0, div_shift_s} - {2'b00, d_r};
        if (is_div_r) begin
            if (!div_diff_s[WIDTH+1]) begin
                step_hi_s = div_diff_s[WIDTH-1:0];
                step_lo_s = {acc_lo_r[WIDTH-2:0], 1'b1};
            end else begin
                step_hi_s = div_shift_s[WIDTH-1:0];
                step_lo_s = {acc_lo_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi_s = mul_sum_s[WIDTH:1];
            step_lo_s = {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
        end
    end

    // Final HI/LO value; divide-by-zero overrides the core result.
    always_comb begin
        res_hi_s = fix_hi_s;
        res_lo_s = fix_lo_s;
        if (is_div_r && b_zero_r) begin
            res_hi_s = a_raw_r;
            res_lo_s = {WIDTH{1'b1}};
        end else begin
            res_hi_s = fix_hi_s;
            res_lo_s = fix_lo_s;
        end
    end

    // Datapath, HI/LO and handshake registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_r      <= {CNT_W{1'b0}};
            is_div_r   <= 1'b0;
            b_zero_r   <= 1'b0;
            a_raw_r    <= {WIDTH{1'b0}};
            d_r        <= {WIDTH{1'b0}};
            acc_hi_r   <= {WIDTH{1'b0}};
            acc_lo_r   <= {WIDTH{1'b0}};
            hi_r       <= {WIDTH{1'b0}};
            lo_r       <= {WIDTH{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
        end else begin
            busy_r     <= (state_next != S_IDLE);
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (bus.Write_HI) hi_r <= bus.W_Data;
                    if (bus.Write_LO) lo_r <= bus.W_Data;
                    if (bus.Start) begin
                        is_div_r <= bus.Op[0];
                        b_zero_r <= (bus.B == {WIDTH{1'b0}});
                        a_raw_r  <= bus.A;
                        acc_hi_r <= {WIDTH{1'b0}};
                        cnt_r    <= {CNT_W{1'b0}};
                        d_r      <= bus.Op[0] ? b_abs_s : a_abs_s;
                        acc_lo_r <= bus.Op[0] ? a_abs_s : b_abs_s;
                    end
                end
                S_CALC: begin
                    acc_hi_r <= step_hi_s;
                    acc_lo_r <= step_lo_s;
                    cnt_r    <= cnt_r + CNT_W'(1);
                end
                S_FIN: begin
                    hi_r       <= res_hi_s;
                    lo_r       <= res_lo_s;
                    done_r     <= 1'b1;
                    div_zero_r <= is_div_r & b_zero_r;
                end
                default: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign bus.Busy     = busy_r;
    assign bus.Done     = done_r;
    assign bus.Div_Zero = div_zero_r;
    assign bus.HI       = hi_r;
    assign bus.LO       = lo_r;

endmodule

// File: tb/tb_mips_muldiv.sv
// Directed self-checking bench for mips_muldiv (WIDTH = 32). Expected values
// for signed ops follow whether MULDIV_SIGNED_EN is defined for the build.
module tb_mips_muldiv;
    import mips_muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passed = 0;

    mips_muldiv_if #(.WIDTH(32)) bus ();

    mips_muldiv #(.WIDTH(32)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Start an op and wait for Done; lat = cycles from Start edge, -1 on timeout.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic busy1, output int lat);
        @(negedge clk);
        bus.Start = 1'b1; bus.Op = op; bus.A = a; bus.B = b;
        @(negedge clk);
        bus.Start = 1'b0;
        busy1 = bus.Busy;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.Done === 1'b1) begin lat = k; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.Busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.Busy); else passed++;
        checks++; if (bus.Done !== 1'b0 || bus.Div_Zero !== 1'b0) $display("FAIL reset_done: got %b%b want 00", bus.Done, bus.Div_Zero); else passed++;
        checks++; if (bus.HI !== 32'h0 || bus.LO !== 32'h0) $display("FAIL reset_hilo: got %h_%h want 0_0", bus.HI, bus.LO); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_multu();
        logic b1; int lat;
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, b1, lat);
        checks++; if (b1 !== 1'b1) $display("FAIL multu_busy: got %b want 1", b1); else passed++;
        checks++; if (lat != 33) $display("FAIL multu_latency: got %0d want 33", lat); else passed++;
        checks++; if (bus.HI !== 32'hFFFF_FFFE || bus.LO !== 32'h0000_0001) $display("FAIL multu_result: got %h_%h want fffffffe_00000001", bus.HI, bus.LO); else passed++;
        @(negedge clk);
        checks++; if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) $display("FAIL multu_done_pulse: got done=%b busy=%b want 0 0", bus.Done, bus.Busy); else passed++;
    endtask

    task automatic test_mult();
        logic b1; int lat;
        logic [31:0] eh;
`ifdef MULDIV_SIGNED_EN
        eh = 32'hFFFF_FFFF;
`else
        eh = 32'h0000_0006;
`endif
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007, b1, lat);
        checks++; if (lat != 33) $display("FAIL mult_latency: got %0d want 33", lat); else passed++;
        checks++; if (bus.HI !== eh || bus.LO !== 32'hFFFF_FFEB) $display("FAIL mult_result: got %h_%h want %h_ffffffeb", bus.HI, bus.LO, eh); else passed++;
    endtask

    task automatic test_div();
        logic [1:0]  ops [3];
        logic [31:0] as [3], bs [3], ehs [3], els [3];
        logic b1; int lat;
        ops[0] = OP_DIVU; as[0] = 32'd100;        bs[0] = 32'd7;          ehs[0] = 32'd2; els[0] = 32'd14;
        ops[1] = OP_DIV;  as[1] = 32'hFFFF_FFF9;  bs[1] = 32'd2;
        ops[2] = OP_DIV;  as[2] = 32'h8000_0000;  bs[2] = 32'hFFFF_FFFF;
`ifdef MULDIV_SIGNED_EN
        ehs[1] = 32'hFFFF_FFFF; els[1] = 32'hFFFF_FFFD;
        ehs[2] = 32'h0000_0000; els[2] = 32'h8000_0000;
`else
        ehs[1] = 32'h0000_0001; els[1] = 32'h7FFF_FFFC;
        ehs[2] = 32'h8000_0000; els[2] = 32'h0000_0000;
`endif
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], as[i], bs[i], b1, lat);
            checks++; if (lat != 33) $display("FAIL div%0d_latency: got %0d want 33", i, lat); else passed++;
            checks++; if (bus.HI !== ehs[i] || bus.LO !== els[i] || bus.Div_Zero !== 1'b0)
                $display("FAIL div%0d_result: got %h_%h dz=%b want %h_%h dz=0", i, bus.HI, bus.LO, bus.Div_Zero, ehs[i], els[i]);
            else passed++;
        end
    endtask

    task automatic test_div_zero();
        logic b1; int lat;
        run_op(OP_DIVU, 32'd5, 32'd0, b1, lat);
        checks++; if (lat != 33) $display("FAIL divz_latency: got %0d want 33", lat); else passed++;
        checks++; if (bus.HI !== 32'h5 || bus.LO !== 32'hFFFF_FFFF || bus.Div_Zero !== 1'b1)
            $display("FAIL divz_result: got %h_%h dz=%b want 00000005_ffffffff dz=1", bus.HI, bus.LO, bus.Div_Zero);
        else passed++;
        @(negedge clk);
        checks++; if (bus.Div_Zero !== 1'b0 || bus.Done !== 1'b0) $display("FAIL divz_pulse: got dz=%b done=%b want 0 0", bus.Div_Zero, bus.Done); else passed++;
    endtask

    task automatic test_busy_ignore();
        int lat;
        @(negedge clk);
        bus.Start = 1'b1; bus.Op = OP_MULTU; bus.A = 32'd2; bus.B = 32'd3;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (4) @(negedge clk);
        bus.Start = 1'b1; bus.Op = OP_DIVU; bus.A = 32'd9; bus.B = 32'd3;
        bus.Write_HI = 1'b1; bus.W_Data = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.Start = 1'b0; bus.Write_HI = 1'b0;
        checks++; if (bus.HI !== 32'h5) $display("FAIL busy_write_hi: got %h want 00000005", bus.HI); else passed++;
        lat = -1;
        for (int k = 6; k <= 45; k++) begin
            @(negedge clk);
            if (bus.Done === 1'b1) begin lat = k; break; end
        end
        checks++; if (lat != 33) $display("FAIL busy_latency: got %0d want 33", lat); else passed++;
        checks++; if (bus.HI !== 32'h0 || bus.LO !== 32'h6) $display("FAIL busy_result: got %h_%h want 0_6", bus.HI, bus.LO); else passed++;
        bus.Write_LO = 1'b1; bus.W_Data = 32'h1234_5678;
        @(negedge clk);
        bus.Write_LO = 1'b0;
        checks++; if (bus.LO !== 32'h1234_5678 || bus.HI !== 32'h0) $display("FAIL mtlo: got %h_%h want 0_12345678", bus.HI, bus.LO); else passed++;
    endtask

    task automatic test_write_start();
        int lat;
        @(negedge clk);
        bus.Start = 1'b1; bus.Op = OP_MULTU; bus.A = 32'd4; bus.B = 32'd5;
        bus.Write_HI = 1'b1; bus.Write_LO = 1'b1; bus.W_Data = 32'hAAAA_5555;
        @(negedge clk);
        bus.Start = 1'b0; bus.Write_HI = 1'b0; bus.Write_LO = 1'b0;
        checks++; if (bus.HI !== 32'hAAAA_5555 || bus.LO !== 32'hAAAA_5555 || bus.Busy !== 1'b1)
            $display("FAIL wr_start_same: got %h_%h busy=%b want aaaa5555_aaaa5555 busy=1", bus.HI, bus.LO, bus.Busy);
        else passed++;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.Done === 1'b1) begin lat = k; break; end
        end
        checks++; if (lat != 33) $display("FAIL wr_start_latency: got %0d want 33", lat); else passed++;
        checks++; if (bus.HI !== 32'h0 || bus.LO !== 32'h14) $display("FAIL wr_start_result: got %h_%h want 0_14", bus.HI, bus.LO); else passed++;
    endtask

    task automatic test_reset_abort();
        int dones;
        @(negedge clk);
        bus.Start = 1'b1; bus.Op = OP_MULTU; bus.A = 32'hFFFF_FFFF; bus.B = 32'd2;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.Busy !== 1'b0 || bus.HI !== 32'h0 || bus.LO !== 32'h0)
            $display("FAIL abort_state: got busy=%b %h_%h want busy=0 0_0", bus.Busy, bus.HI, bus.LO);
        else passed++;
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.Done === 1'b1) dones++;
        end
        checks++; if (dones != 0) $display("FAIL abort_no_done: got %0d pulses want 0", dones); else passed++;
    endtask

    initial begin
        rst = 1'b1;
        bus.Start = 1'b0; bus.Op = 2'b00; bus.A = 32'h0; bus.B = 32'h0;
        bus.Write_HI = 1'b0; bus.Write_LO = 1'b0; bus.W_Data = 32'h0;
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_div_zero();
        test_busy_ignore();
        test_write_start();
        test_reset_abort();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
